mem_access_initiator: RTL and testbench
=======================================

Name: mem_access_initiator

Overview:
- CPU-side initiator for the data-memory stall handshake.
- Accepts one load/store request at a time from the pipeline and checks alignment.
- Drives addr / write_data / memwrite / memread / sign_mask as a one-cycle strobe, tracks clk_stall until completion, and returns load data or a store acknowledge on a response pulse.
- Adds a stall timeout so a hung memory cannot lock the core.

Parameters:
- STALL_TIMEOUT, 15, maximum WAIT cycles with mem_clk_stall high before error; counter is 5 bits wide.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid & req_ready at posedge
- req_we  in  1  1=store, 0=load
- req_funct3  in  3  RV32 width code: 000 B, 001 H, 010 W, 100 BU, 101 HU (stores use 000/001/010 only)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  load result, extended; 0 for stores and errors
- resp_err  out  2  00 ok, 01 misaligned, 10 timeout, 11 illegal funct3
- busy  out  1  high in any state other than IDLE
- mem_addr  out  32  to memory addr
- mem_wdata  out  32  to memory write_data
- mem_memwrite  out  1  store strobe
- mem_memread  out  1  load strobe
- mem_sign_mask  out  4  [3]=signed; [2:0]: 001 byte, 011 half, 111 word
- mem_read_data  in  32  memory read_data
- mem_clk_stall  in  1  memory busy

Behaviour:
- Reset values:
  - state=IDLE; req_ready=0 in the reset cycle.
  - resp_valid=0, resp_rdata=0, resp_err=00, busy=0.
  - mem_memread=0, mem_memwrite=0, mem_addr=0, mem_wdata=0, mem_sign_mask=0; timeout counter=0.
- req_ready = (state==IDLE) & ~mem_clk_stall & ~rst. This drains any memory transaction left in flight by a mid-operation reset, since the memory has no reset.
- Accept: on a posedge with req_valid & req_ready, register addr, wdata, we and funct3.
  - sign_mask mapping: B→1001, BU→0001, H→1011, HU→0011, W→0111. Store sign bit is don't-care, driven 0.
- Illegal funct3 (011, 110, 111, or a store with funct3[2]=1): go to RESP with err=11 and no memory strobe.
- Misaligned (H/HU with addr[0]=1; W with addr[1:0]≠00): go to RESP with err=01 and no memory strobe.
- States:
  - IDLE: waits for an accepted request. Next state is ISSUE, or RESP for an error.
  - ISSUE: exactly one cycle. mem_memread=~we, mem_memwrite=we; mem_addr, mem_wdata and mem_sign_mask are held from the accept cycle through WAIT. Next state is WAIT.
  - WAIT: strobes held 0 so the memory does not re-trigger. Counter increments each cycle mem_clk_stall=1.
    - mem_clk_stall=0: capture mem_read_data (loads) into resp_rdata, err=00, go to RESP.
    - Counter reaches STALL_TIMEOUT: err=10, resp_rdata=0, go to RESP. The memory is not aborted; req_ready stays low until stall drops.
  - RESP: resp_valid=1 for one cycle, then IDLE. resp_rdata and resp_err hold until the next RESP. Counter clears.
- Latency for a well-behaved memory (1-cycle stall assert, 2 stall cycles): accept edge A; ISSUE sampled by the memory at A+1; stall high after A+1 and A+2; low after A+3; capture at A+4; resp_valid high during the cycle after A+4. Loads and stores are identical.
- Throughput: one request per 6 cycles minimum. No request is accepted in RESP.
- The memory performs extension, so resp_rdata passes through unmodified. Stores return resp_rdata=0.
- rst during any state: next state is IDLE, all outputs go to reset values, and the pending request is dropped with no resp_valid.
- rst and req_valid in the same cycle: the request is not accepted.

Test Plan:
- LW addr=0x0000_0010, memory word 0xDEADBEEF → one mem_memread pulse with sign_mask=0111; resp_valid 4 edges after accept; rdata=0xDEADBEEF; err=00.
- SB addr=0x0000_0013, wdata=0x0000_00A5 → one mem_memwrite pulse with sign_mask=0001, mem_addr=0x13; then LBU same addr → rdata=0x0000_00A5; LB → 0xFFFF_FFA5.
- LH addr=0x0000_0021 → no memory strobe; resp_valid 1 cycle after accept with err=01, rdata=0. SW addr=0x0000_0022 → same.
- Memory model holds mem_clk_stall=1 indefinitely → err=10 exactly STALL_TIMEOUT WAIT cycles after ISSUE; req_ready stays 0 until stall is released.
- rst asserted in WAIT while mem_clk_stall=1 → no resp_valid; req_ready=0 until stall falls; next LW completes with correct data.
- Back-to-back requests with req_valid held high → strobes never asserted two consecutive cycles; each request completes with err=00.

Source files
------------

// File: rtl/mem_access_initiator_if.sv
// Pipeline request/response and data-memory bus bundle for mem_access_initiator.
interface mem_access_initiator_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_err;
  logic        busy;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_memwrite;
  logic        mem_memread;
  logic [3:0]  mem_sign_mask;
  logic [31:0] mem_read_data;
  logic        mem_clk_stall;

  modport master (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  mem_read_data, mem_clk_stall,
    output req_ready, resp_valid, resp_rdata, resp_err, busy,
    output mem_addr, mem_wdata, mem_memwrite, mem_memread, mem_sign_mask
  );

  modport slave (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    output mem_read_data, mem_clk_stall,
    input  req_ready, resp_valid, resp_rdata, resp_err, busy,
    input  mem_addr, mem_wdata, mem_memwrite, mem_memread, mem_sign_mask
  );
endinterface

// File: rtl/mem_access_initiator.sv
// Data-memory stall-handshake initiator: one load/store at a time, alignment
// and width checks, one-cycle memory strobe, stall tracking with timeout.
module mem_access_initiator #(
  parameter int unsigned STALL_TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  mem_access_initiator_if.master mif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;
  localparam logic [4:0] TIMEOUT_C = 5'(STALL_TIMEOUT);

  function automatic logic illegal_f(input logic we, input logic [2:0] f3);
    logic r;
    case (f3)
      3'b000, 3'b001, 3'b010: r = 1'b0;
      3'b100, 3'b101:         r = we;
      default:                r = 1'b1;
    endcase
    return r;
  endfunction

  function automatic logic misaligned_f(input logic [2:0] f3, input logic [1:0] a);
    logic r;
    case (f3[1:0])
      2'b01:   r = a[0];
      2'b10:   r = (a != 2'b00);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] mask_f(input logic we, input logic [2:0] f3);
    logic [3:0] r;
    case (f3)
      3'b000:  r = we ? 4'b0001 : 4'b1001;
      3'b001:  r = we ? 4'b0011 : 4'b1011;
      3'b010:  r = 4'b0111;
      3'b100:  r = 4'b0001;
      3'b101:  r = 4'b0011;
      default: r = 4'b0000;
    endcase
    return r;
  endfunction

  logic [1:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  mask_q, mask_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic        rv_q, rv_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  err_q, err_d;
  logic        busy_q, busy_d;
  logic        ready_s;
  logic        accept_s;
  logic [4:0]  cnt_inc_s;

  // Holding off while stall is high drains a transfer orphaned by reset.
  assign ready_s   = (state_q == S_IDLE) & ~mif.mem_clk_stall & ~rst;
  assign accept_s  = mif.req_valid & ready_s;
  assign cnt_inc_s = cnt_q + 5'd1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    mask_d  = mask_q;
    rd_d    = 1'b0;
    wr_d    = 1'b0;
    rv_d    = 1'b0;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = 5'd0;
        if (accept_s) begin
          we_d    = mif.req_we;
          addr_d  = mif.req_addr;
          wdata_d = mif.req_wdata;
          mask_d  = mask_f(mif.req_we, mif.req_funct3);
          if (illegal_f(mif.req_we, mif.req_funct3)) begin
            state_d = S_RESP;
            err_d   = 2'b11;
            rdata_d = 32'd0;
            rv_d    = 1'b1;
          end else if (misaligned_f(mif.req_funct3, mif.req_addr[1:0])) begin
            state_d = S_RESP;
            err_d   = 2'b01;
            rdata_d = 32'd0;
            rv_d    = 1'b1;
          end else begin
            state_d = S_ISSUE;
            rd_d    = ~mif.req_we;
            wr_d    = mif.req_we;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (!mif.mem_clk_stall) begin
          state_d = S_RESP;
          err_d   = 2'b00;
          rdata_d = we_q ? 32'd0 : mif.mem_read_data;
          rv_d    = 1'b1;
        end else begin
          cnt_d = cnt_inc_s;
          if (cnt_inc_s == TIMEOUT_C) begin
            state_d = S_RESP;
            err_d   = 2'b10;
            rdata_d = 32'd0;
            rv_d    = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        cnt_d   = 5'd0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 5'd0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs, synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 5'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      mask_q  <= 4'd0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      rv_q    <= 1'b0;
      rdata_q <= 32'd0;
      err_q   <= 2'b00;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      mask_q  <= mask_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      rv_q    <= rv_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign mif.req_ready     = ready_s;
  assign mif.resp_valid    = rv_q;
  assign mif.resp_rdata    = rdata_q;
  assign mif.resp_err      = err_q;
  assign mif.busy          = busy_q;
  assign mif.mem_addr      = addr_q;
  assign mif.mem_wdata     = wdata_q;
  assign mif.mem_memwrite  = wr_q;
  assign mif.mem_memread   = rd_q;
  assign mif.mem_sign_mask = mask_q;

endmodule

// File: tb/tb_mem_access_initiator.sv
// Bench for mem_access_initiator: stalling byte-memory model, per-cycle
// transaction-level reference model, directed and randomized requests.
module tb_mem_access_initiator;
  localparam int TMO = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_access_initiator_if mif ();

  mem_access_initiator #(.STALL_TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .mif (mif)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int e      = 0;
  int stall_len = 2;
  bit hang   = 1'b0;
  logic [7:0] mem_b [0:255];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, e);
    end
  endtask

  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a);
    int n;
    logic [31:0] v;
    logic [7:0] idx;
    n = 1 << f3[1:0];
    v = 32'd0;
    for (int i = 0; i < n; i++) begin
      idx = a[7:0] + 8'(i);
      v = v | (32'(mem_b[idx]) << (8 * i));
    end
    if (!f3[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  always @(posedge clk) e = e + 1;

  // Memory: samples a strobe at the edge, stalls for stall_len cycles (or while hang).
  initial begin : mem_model
    logic [31:0] ma, mw, v;
    logic [3:0] mm;
    logic mwe;
    logic [7:0] idx;
    int n;
    for (int i = 0; i < 256; i++) mem_b[i] = 8'($urandom);
    mem_b[16] = 8'hEF; mem_b[17] = 8'hBE; mem_b[18] = 8'hAD; mem_b[19] = 8'hDE;
    mif.mem_clk_stall = 1'b0;
    mif.mem_read_data = 32'd0;
    forever begin
      @(negedge clk);
      if (mif.mem_memread === 1'b1 || mif.mem_memwrite === 1'b1) begin
        ma = mif.mem_addr; mw = mif.mem_wdata; mm = mif.mem_sign_mask; mwe = mif.mem_memwrite;
        n = (mm[2:0] == 3'b111) ? 4 : ((mm[2:0] == 3'b011) ? 2 : 1);
        @(posedge clk); #1;
        if (mwe) begin
          for (int i = 0; i < n; i++) begin
            idx = ma[7:0] + 8'(i);
            mem_b[idx] = mw[8*i +: 8];
          end
        end else begin
          v = 32'd0;
          for (int i = 0; i < n; i++) begin
            idx = ma[7:0] + 8'(i);
            v = v | (32'(mem_b[idx]) << (8 * i));
          end
          if (mm[3] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
          mif.mem_read_data = v;
        end
        if (hang) begin
          mif.mem_clk_stall = 1'b1;
          while (hang) @(posedge clk);
          #1 mif.mem_clk_stall = 1'b0;
        end else if (stall_len > 0) begin
          mif.mem_clk_stall = 1'b1;
          repeat (stall_len) @(posedge clk);
          #1 mif.mem_clk_stall = 1'b0;
        end
      end
    end
  end

  // Reference model: one outstanding transaction with known strobe/response edges.
  bit pend = 1'b0;
  bit rst_seen = 1'b1;
  bit ok_m, we_m;
  int a_e, lat_l;
  logic [1:0]  xerr, hold_err = 2'b00;
  logic [31:0] xrdata, xaddr, xwdata, hold_rd = 32'd0;
  logic [3:0]  xmask;

  always @(negedge clk) begin : compare
    bit exp_busy, exp_rv, exp_ready;
    logic [2:0] f3;
    int sz;
    if (e >= 1) begin
      if (rst_seen) begin
        pend = 1'b0; hold_rd = 32'd0; hold_err = 2'b00;
      end
      exp_busy  = pend && e >= a_e && e <= a_e + lat_l;
      exp_rv    = pend && e == a_e + lat_l;
      if (exp_rv) begin
        hold_rd = xrdata; hold_err = xerr;
      end
      exp_ready = !exp_busy && !mif.mem_clk_stall && !rst;
      chk("resp_valid", 32'(mif.resp_valid), 32'(exp_rv));
      chk("busy", 32'(mif.busy), 32'(exp_busy));
      chk("req_ready", 32'(mif.req_ready), 32'(exp_ready));
      chk("resp_rdata", mif.resp_rdata, hold_rd);
      chk("resp_err", 32'(mif.resp_err), 32'(hold_err));
      chk("mem_memread", 32'(mif.mem_memread), 32'(pend && ok_m && !we_m && e == a_e));
      chk("mem_memwrite", 32'(mif.mem_memwrite), 32'(pend && ok_m && we_m && e == a_e));
      if (pend && ok_m && e >= a_e && e < a_e + lat_l) begin
        chk("mem_addr", mif.mem_addr, xaddr);
        chk("mem_wdata", mif.mem_wdata, xwdata);
        chk("mem_sign_mask", 32'(mif.mem_sign_mask), 32'(xmask));
      end
      if (rst_seen) begin
        chk("rst_mem_addr", mif.mem_addr, 32'd0);
        chk("rst_mem_wdata", mif.mem_wdata, 32'd0);
        chk("rst_sign_mask", 32'(mif.mem_sign_mask), 32'd0);
      end
      if (exp_rv) pend = 1'b0;
      if (mif.req_valid && exp_ready) begin
        we_m = mif.req_we; f3 = mif.req_funct3;
        xaddr = mif.req_addr; xwdata = mif.req_wdata;
        sz = 1 << f3[1:0];
        xmask = {(!we_m && !f3[2] && sz < 4), 3'((2 << f3[1:0]) - 1)};
        ok_m = 1'b0; xrdata = 32'd0; lat_l = 0;
        if (f3[1:0] == 2'd3 || (f3[2] && (we_m || f3[1:0] == 2'd2))) xerr = 2'b11;
        else if ((xaddr % sz) != 0) xerr = 2'b01;
        else begin
          ok_m = 1'b1;
          if (hang || stall_len >= TMO) begin
            xerr = 2'b10; lat_l = TMO + 1;
          end else begin
            xerr = 2'b00; lat_l = 2 + stall_len;
            xrdata = we_m ? 32'd0 : exp_load(f3, xaddr);
          end
        end
        a_e = e + 1; pend = 1'b1;
      end
    end
    rst_seen = rst;
  end

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input int sl, input bit wait_resp,
                        input bit keep_valid, output logic [31:0] rd,
                        output logic [1:0] err, output int lat);
    bit acc, got;
    @(posedge clk); #1;
    stall_len = sl;
    mif.req_valid = 1'b1; mif.req_we = we; mif.req_funct3 = f3;
    mif.req_addr = addr; mif.req_wdata = wd;
    acc = 1'b0;
    for (int n = 0; n < 60 && !acc; n++) begin
      @(negedge clk); acc = mif.req_ready;
      @(posedge clk); #1;
    end
    if (!keep_valid) mif.req_valid = 1'b0;
    rd = 32'd0; err = 2'b00; lat = -1;
    if (!acc) begin
      n_cmp++; n_fail++;
      $display("FAIL accept_timeout: got no req_ready expected accept (edge %0d)", e);
    end else if (wait_resp) begin
      got = 1'b0; lat = 0;
      for (int k = 0; k < 40 && !got; k++) begin
        @(negedge clk);
        if (mif.resp_valid) got = 1'b1;
        else begin
          @(posedge clk); lat++;
        end
      end
      if (!got) begin
        n_cmp++; n_fail++;
        $display("FAIL resp_timeout: got no resp_valid expected one (edge %0d)", e);
      end
      rd = mif.resp_rdata; err = mif.resp_err;
    end
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: got no end of test expected finish");
    $fatal(1);
  end

  initial begin : main
    logic [31:0] rd, addr, wd;
    logic [1:0] err;
    logic [2:0] f3;
    logic we;
    int lat, sl;
    mif.req_valid = 1'b1; mif.req_we = 1'b0; mif.req_funct3 = 3'b010;
    mif.req_addr = 32'h10; mif.req_wdata = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_req_ready", 32'(mif.req_ready), 32'd0);
    chk("reset_busy", 32'(mif.busy), 32'd0);
    chk("reset_mem_addr", mif.mem_addr, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; mif.req_valid = 1'b0;

    do_req(1'b0, 3'b010, 32'h10, 32'd0, 2, 1'b1, 1'b0, rd, err, lat);
    chk("lw_rdata", rd, 32'hDEADBEEF); chk("lw_err", 32'(err), 32'd0); chk("lw_lat", 32'(lat), 32'd4);
    do_req(1'b1, 3'b000, 32'h13, 32'hA5, 2, 1'b1, 1'b0, rd, err, lat);
    chk("sb_rdata", rd, 32'd0); chk("sb_err", 32'(err), 32'd0); chk("sb_lat", 32'(lat), 32'd4);
    do_req(1'b0, 3'b100, 32'h13, 32'd0, 2, 1'b1, 1'b0, rd, err, lat);
    chk("lbu_rdata", rd, 32'h0000_00A5);
    do_req(1'b0, 3'b000, 32'h13, 32'd0, 2, 1'b1, 1'b0, rd, err, lat);
    chk("lb_rdata", rd, 32'hFFFF_FFA5);
    do_req(1'b0, 3'b001, 32'h21, 32'd0, 2, 1'b1, 1'b0, rd, err, lat);
    chk("lh_mis_err", 32'(err), 32'd1); chk("lh_mis_rdata", rd, 32'd0); chk("lh_mis_lat", 32'(lat), 32'd0);
    do_req(1'b1, 3'b010, 32'h22, 32'h1234, 2, 1'b1, 1'b0, rd, err, lat);
    chk("sw_mis_err", 32'(err), 32'd1); chk("sw_mis_lat", 32'(lat), 32'd0);
    do_req(1'b0, 3'b011, 32'h10, 32'd0, 2, 1'b1, 1'b0, rd, err, lat);
    chk("ill_ld_err", 32'(err), 32'd3);
    do_req(1'b1, 3'b100, 32'h10, 32'd0, 2, 1'b1, 1'b0, rd, err, lat);
    chk("ill_st_err", 32'(err), 32'd3);

    @(posedge clk); #1 hang = 1'b1;
    do_req(1'b0, 3'b010, 32'h10, 32'd0, 2, 1'b1, 1'b0, rd, err, lat);
    chk("tmo_err", 32'(err), 32'd2); chk("tmo_rdata", rd, 32'd0); chk("tmo_lat", 32'(lat), 32'(TMO + 1));
    repeat (5) @(posedge clk);
    #1 hang = 1'b0;
    repeat (3) @(posedge clk);
    do_req(1'b0, 3'b010, 32'h40, 32'd0, TMO - 1, 1'b1, 1'b0, rd, err, lat);
    chk("stall14_err", 32'(err), 32'd0); chk("stall14_lat", 32'(lat), 32'(TMO + 1));
    do_req(1'b0, 3'b010, 32'h40, 32'd0, TMO, 1'b1, 1'b0, rd, err, lat);
    chk("stall15_err", 32'(err), 32'd2);

    @(posedge clk); #1 hang = 1'b1;
    do_req(1'b0, 3'b010, 32'h10, 32'd0, 2, 1'b0, 1'b0, rd, err, lat);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    #1 hang = 1'b0;
    do_req(1'b0, 3'b010, 32'h10, 32'd0, 2, 1'b1, 1'b0, rd, err, lat);
    chk("post_rst_lw", rd, 32'hA5ADBEEF); chk("post_rst_err", 32'(err), 32'd0);

    do_req(1'b1, 3'b010, 32'h80, 32'h1234_5678, 2, 1'b1, 1'b1, rd, err, lat);
    chk("b2b_sw_err", 32'(err), 32'd0);
    do_req(1'b0, 3'b010, 32'h80, 32'd0, 0, 1'b1, 1'b1, rd, err, lat);
    chk("b2b_lw_rdata", rd, 32'h1234_5678);
    do_req(1'b1, 3'b001, 32'h82, 32'h0000_8001, 1, 1'b1, 1'b1, rd, err, lat);
    chk("b2b_sh_err", 32'(err), 32'd0);
    do_req(1'b0, 3'b001, 32'h82, 32'd0, 3, 1'b1, 1'b0, rd, err, lat);
    chk("b2b_lh_rdata", rd, 32'hFFFF_8001);

    for (int k = 0; k < 80; k++) begin
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 4) != 0) begin
        case ($urandom_range(0, 4))
          0: f3 = 3'b000;
          1: f3 = 3'b001;
          2: f3 = 3'b010;
          3: f3 = 3'b100;
          default: f3 = 3'b101;
        endcase
      end
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
      wd = $urandom;
      sl = ($urandom_range(0, 9) == 0) ? $urandom_range(TMO - 2, TMO + 1) : $urandom_range(0, 4);
      do_req(we, f3, addr, wd, sl, 1'b1, (k != 79) && ($urandom_range(0, 1) == 1), rd, err, lat);
    end
    mif.req_valid = 1'b0;
    repeat (25) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
